// File: rtl/traffic_pkg.sv
// Shared types and constants for the two-road phase scheduler.
// The TRAFFIC_FLASH_EN build uses the FLASH encoding and LAMP_OFF.
package traffic_pkg;

   localparam int unsigned CNT_W = 6;

   localparam logic [2:0] LAMP_G   = 3'b100;
   localparam logic [2:0] LAMP_R   = 3'b010;
   localparam logic [2:0] LAMP_Y   = 3'b001;
   localparam logic [2:0] LAMP_OFF = 3'b000;

   typedef enum logic [2:0] {
      PhG1    = 3'd0,
      PhY1    = 3'd1,
      PhAr1   = 3'd2,
      PhG2    = 3'd3,
      PhY2    = 3'd4,
      PhAr2   = 3'd5,
      PhFlash = 3'd6
   } phase_e;

   // Returns {light1, light2}. FLASH lamps depend on the blink register, so the caller owns that case.
   function automatic logic [5:0] phase_lamps(input phase_e ph);
      unique case (ph)
         PhG1:    phase_lamps = {LAMP_G, LAMP_R};
         PhY1:    phase_lamps = {LAMP_Y, LAMP_R};
         PhG2:    phase_lamps = {LAMP_R, LAMP_G};
         PhY2:    phase_lamps = {LAMP_R, LAMP_Y};
         default: phase_lamps = {LAMP_R, LAMP_R};
      endcase
   endfunction

endpackage

// File: rtl/traffic_phase_sched_if.sv
// Bus bundle between the scheduler and its environment.
// The flash input exists only when TRAFFIC_FLASH_EN is defined.
interface traffic_phase_sched_if;
   import traffic_pkg::*;

   logic             tick;
   logic             req1;
   logic             req2;
   logic [2:0]       light1;
   logic [2:0]       light2;
   logic [CNT_W-1:0] count;
   logic [2:0]       phase;
`ifdef TRAFFIC_FLASH_EN
   logic             flash;

   modport master (output tick, req1, req2, flash, input light1, light2, count, phase);
   modport slave  (input tick, req1, req2, flash, output light1, light2, count, phase);
`else
   modport master (output tick, req1, req2, input light1, light2, count, phase);
   modport slave  (input tick, req1, req2, output light1, light2, count, phase);
`endif

endinterface

// File: rtl/traffic_phase_sched_phase_timer.sv
// Loadable tick-enabled down-counter that stops at zero; expire marks the tick that ends a count of 1.
module phase_timer
   import traffic_pkg::*;
#(
   parameter int unsigned RST_VAL = 20
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             tick_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic [CNT_W-1:0] count_o,
   output logic             expire_o
);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (tick_i && (count_q != '0)) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= CNT_W'(RST_VAL);
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o  = count_q;
   assign expire_o = tick_i && (count_q == CNT_W'(1));

endmodule

// File: rtl/traffic_phase_sched.sv
// Demand-responsive phase scheduler for a two-road intersection with rest-in-green.
// Defining TRAFFIC_FLASH_EN adds the flashing-yellow override driven by bus.flash.
module traffic_phase_sched
   import traffic_pkg::*;
#(
   parameter int unsigned GREEN_T  = 20,
   parameter int unsigned YELLOW_T = 3,
   parameter int unsigned ALLRED_T = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   traffic_phase_sched_if.slave  bus
);

   phase_e           state_q, state_d;
   logic             pend1_q, pend1_d, pend2_q, pend2_d;
   logic [2:0]       light1_q, light1_d, light2_q, light2_d;
   logic             load;
   logic [CNT_W-1:0] load_val, count;
   logic             expire, green_done;
`ifdef TRAFFIC_FLASH_EN
   logic             blink_q, blink_d;
`endif

   phase_timer #(
      .RST_VAL (GREEN_T)
   ) u_timer (
      .clk_i      (clk),
      .rst_i      (rst_n),
      .tick_i     (bus.tick),
      .load_i     (load),
      .load_val_i (load_val),
      .count_o    (count),
      .expire_o   (expire)
   );

   // A green may end on the expiring tick or on any later tick while resting at 0.
   assign green_done = expire || (bus.tick && (count == '0));

   always_comb begin
      state_d  = state_q;
      load     = 1'b0;
      load_val = '0;
      case (state_q)
         PhG1:  if (green_done && pend2_q) begin state_d = PhY1;  load = 1'b1; load_val = CNT_W'(YELLOW_T); end
         PhY1:  if (expire)                begin state_d = PhAr1; load = 1'b1; load_val = CNT_W'(ALLRED_T); end
         PhAr1: if (expire)                begin state_d = PhG2;  load = 1'b1; load_val = CNT_W'(GREEN_T);  end
         PhG2:  if (green_done && pend1_q) begin state_d = PhY2;  load = 1'b1; load_val = CNT_W'(YELLOW_T); end
         PhY2:  if (expire)                begin state_d = PhAr2; load = 1'b1; load_val = CNT_W'(ALLRED_T); end
         PhAr2: if (expire)                begin state_d = PhG1;  load = 1'b1; load_val = CNT_W'(GREEN_T);  end
         default: ;
      endcase

      pend1_d = (pend1_q || (bus.req1 && (state_q != PhG1))) && !((state_d == PhG1) && (state_q != PhG1));
      pend2_d = (pend2_q || (bus.req2 && (state_q != PhG2))) && !((state_d == PhG2) && (state_q != PhG2));

`ifdef TRAFFIC_FLASH_EN
      blink_d = blink_q;
      if (bus.flash) begin
         state_d  = PhFlash;
         load     = 1'b1;
         load_val = '0;
         pend1_d  = 1'b0;
         pend2_d  = 1'b0;
         blink_d  = (state_q != PhFlash) ? 1'b1 : (bus.tick ? !blink_q : blink_q);
      end else if (state_q == PhFlash) begin
         state_d  = PhAr2;
         load     = 1'b1;
         load_val = CNT_W'(ALLRED_T);
      end
`endif

      {light1_d, light2_d} = phase_lamps(state_d);
`ifdef TRAFFIC_FLASH_EN
      if (state_d == PhFlash) begin
         light1_d = blink_d ? LAMP_Y : LAMP_OFF;
         light2_d = blink_d ? LAMP_Y : LAMP_OFF;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q  <= PhG1;
         pend1_q  <= 1'b0;
         pend2_q  <= 1'b0;
         light1_q <= LAMP_G;
         light2_q <= LAMP_R;
`ifdef TRAFFIC_FLASH_EN
         blink_q  <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         pend1_q  <= pend1_d;
         pend2_q  <= pend2_d;
         light1_q <= light1_d;
         light2_q <= light2_d;
`ifdef TRAFFIC_FLASH_EN
         blink_q  <= blink_d;
`endif
      end
   end

   assign bus.light1 = light1_q;
   assign bus.light2 = light2_q;
   assign bus.count  = count;
   assign bus.phase  = state_q;

endmodule

// File: tb/tb_traffic_phase_sched.sv
// Directed bench for traffic_phase_sched: expected states queued before each edge, checked after it.
module tb_traffic_phase_sched;

   typedef struct {
      string      tag;
      logic [2:0] ph;
      logic [5:0] cnt;
      logic [2:0] l1;
      logic [2:0] l2;
   } exp_t;

   logic  clk = 1'b0;
   logic  rst_n;
   exp_t  sb[$];
   int    errors = 0;
   int    checks = 0;

   traffic_phase_sched_if bus ();

   traffic_phase_sched #(
      .GREEN_T  (20),
      .YELLOW_T (3),
      .ALLRED_T (1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic exp_raw(input string tag, input logic [2:0] ph, input int cnt,
                          input logic [2:0] l1, input logic [2:0] l2);
      exp_t e;
      e.tag = tag;
      e.ph  = ph;
      e.cnt = 6'(cnt);
      e.l1  = l1;
      e.l2  = l2;
      sb.push_back(e);
   endtask

   task automatic exp_ph(input string tag, input logic [2:0] ph, input int cnt);
      logic [2:0] l1, l2;
      case (ph)
         3'd0:    begin l1 = 3'b100; l2 = 3'b010; end
         3'd1:    begin l1 = 3'b001; l2 = 3'b010; end
         3'd3:    begin l1 = 3'b010; l2 = 3'b100; end
         3'd4:    begin l1 = 3'b010; l2 = 3'b001; end
         default: begin l1 = 3'b010; l2 = 3'b010; end
      endcase
      exp_raw(tag, ph, cnt, l1, l2);
   endtask

   // Drive one cycle of inputs, take the edge, then compare everything queued for it.
   task automatic cyc(input logic t, input logic r1, input logic r2, input logic rs);
      exp_t e;
      bus.tick = t;
      bus.req1 = r1;
      bus.req2 = r2;
      rst_n    = rs;
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         assert ({bus.phase, bus.count, bus.light1, bus.light2} === {e.ph, e.cnt, e.l1, e.l2})
         else begin
            errors++;
            $error("FAIL %s: got phase=%0d count=%0d l1=%b l2=%b, want phase=%0d count=%0d l1=%b l2=%b",
                   e.tag, bus.phase, bus.count, bus.light1, bus.light2, e.ph, e.cnt, e.l1, e.l2);
         end
      end
   endtask

   task automatic tk(input string tag, input logic r1, input logic r2, input logic [2:0] ph,
                     input int cnt);
      exp_ph(tag, ph, cnt);
      cyc(1'b1, r1, r2, 1'b0);
   endtask

   task automatic idle(input string tag, input logic r1, input logic r2, input logic [2:0] ph,
                       input int cnt);
      exp_ph(tag, ph, cnt);
      cyc(1'b0, r1, r2, 1'b0);
   endtask

   initial begin
      bus.tick = 1'b0;
      bus.req1 = 1'b0;
      bus.req2 = 1'b0;
`ifdef TRAFFIC_FLASH_EN
      bus.flash = 1'b0;
`endif
      rst_n = 1'b1;

      // Reset for two cycles, then release.
      exp_ph("rst_a", 3'd0, 20); cyc(1'b1, 1'b1, 1'b1, 1'b1);
      exp_ph("rst_b", 3'd0, 20); cyc(1'b0, 1'b0, 1'b0, 1'b1);
      idle("rst_rel", 1'b0, 1'b0, 3'd0, 20);

      // Served G1 -> Y1 -> AR1 -> G2 with a req2 pulse at count 15.
      for (int i = 19; i >= 15; i--) tk("g1_dec", 1'b0, 1'b0, 3'd0, i);
      idle("req2_pulse", 1'b0, 1'b1, 3'd0, 15);
      for (int i = 14; i >= 1; i--) tk("g1_dec2", 1'b0, 1'b0, 3'd0, i);
      tk("y1_entry", 1'b0, 1'b0, 3'd1, 3);
      tk("y1_2", 1'b0, 1'b0, 3'd1, 2);
      tk("y1_1", 1'b0, 1'b0, 3'd1, 1);
      tk("ar1_entry", 1'b0, 1'b0, 3'd2, 1);
      tk("g2_entry", 1'b0, 1'b0, 3'd3, 20);

      // G2 rests at 0; req2 in G2 is ignored; req1 between ticks ends it on the next tick.
      for (int i = 19; i >= 0; i--) tk("g2_dec", 1'b0, 1'b0, 3'd3, i);
      tk("g2_rest", 1'b0, 1'b0, 3'd3, 0);
      tk("g2_req2_ign", 1'b0, 1'b1, 3'd3, 0);
      idle("g2_req1", 1'b1, 1'b0, 3'd3, 0);
      tk("y2_entry", 1'b0, 1'b0, 3'd4, 3);
      tk("y2_2", 1'b0, 1'b0, 3'd4, 2);
      tk("y2_1", 1'b0, 1'b0, 3'd4, 1);
      tk("ar2_entry", 1'b0, 1'b0, 3'd5, 1);
      tk("g1_entry_req1", 1'b1, 1'b0, 3'd0, 20);

      // req1 held through G1: rest-in-green holds, pend2 was cleared at G2 entry.
      for (int i = 19; i >= 0; i--) tk("g1_hold_dec", 1'b1, 1'b0, 3'd0, i);
      for (int i = 0; i < 10; i++) tk("g1_rest", 1'b1, 1'b0, 3'd0, 0);
      idle("g1_req2_mid", 1'b0, 1'b1, 3'd0, 0);
      for (int i = 0; i < 3; i++) idle("g1_wait_tick", 1'b0, 1'b0, 3'd0, 0);
      tk("y1_from_rest", 1'b0, 1'b0, 3'd1, 3);
      tk("y1_b2", 1'b0, 1'b0, 3'd1, 2);
      tk("y1_b1", 1'b0, 1'b0, 3'd1, 1);
      tk("ar1_b", 1'b0, 1'b0, 3'd2, 1);
      tk("g2_b", 1'b0, 1'b0, 3'd3, 20);

      // pend1 must have been cleared on G1 entry, so G2 rests.
      for (int i = 19; i >= 0; i--) tk("g2_b_dec", 1'b0, 1'b0, 3'd3, i);
      tk("g2_b_rest", 1'b0, 1'b0, 3'd3, 0);

      // No tick for 100 cycles with both demands present: nothing moves.
      for (int i = 0; i < 100; i++) idle("no_tick", 1'b1, 1'b1, 3'd3, 0);

      // Reset during Y2 abandons the phase.
      tk("y2_c", 1'b0, 1'b0, 3'd4, 3);
      tk("y2_c2", 1'b0, 1'b0, 3'd4, 2);
      exp_ph("rst_in_y2", 3'd0, 20); cyc(1'b1, 1'b1, 1'b1, 1'b1);
      tk("post_rst", 1'b0, 1'b0, 3'd0, 19);

`ifdef TRAFFIC_FLASH_EN
      bus.flash = 1'b1;
      exp_raw("flash_entry", 3'd6, 0, 3'b001, 3'b001); cyc(1'b0, 1'b1, 1'b0, 1'b0);
      exp_raw("flash_t1", 3'd6, 0, 3'b000, 3'b000);    cyc(1'b1, 1'b0, 1'b0, 1'b0);
      exp_raw("flash_hold", 3'd6, 0, 3'b000, 3'b000);  cyc(1'b0, 1'b0, 1'b0, 1'b0);
      exp_raw("flash_t2", 3'd6, 0, 3'b001, 3'b001);    cyc(1'b1, 1'b0, 1'b0, 1'b0);
      bus.flash = 1'b0;
      idle("flash_exit", 1'b0, 1'b0, 3'd5, 1);
      tk("flash_g1", 1'b0, 1'b0, 3'd0, 20);
      // pend2 was cleared while flashing, so G1 rests.
      for (int i = 19; i >= 0; i--) tk("flash_g1_dec", 1'b0, 1'b0, 3'd0, i);
      tk("flash_g1_rest", 1'b0, 1'b0, 3'd0, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
